// File: rtl/fetch_unit_if.sv
// fetch_unit_if: byte-wide instruction memory read port (req/ack handshake)
interface fetch_unit_if #(parameter int ADDR_W = 64);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              mem_err;
  modport master(output mem_req, mem_addr, input mem_ack, mem_rdata, mem_err);
  modport slave(input mem_req, mem_addr, output mem_ack, mem_rdata, mem_err);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle Y86-64 fetch, one instruction byte per handshake
module fetch_unit #(parameter int ADDR_W = 64) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] PC,
  fetch_unit_if.master      mem,
  output logic              busy,
  output logic              done,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [63:0]       valC,
  output logic [ADDR_W-1:0] valP,
  output logic              instr_valid,
  output logic              imem_error,
  output logic              halt
);
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, valp_q, valp_d;
  logic [3:0] k_q, k_d, icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d;
  logic iv_q, iv_d, err_q, err_d, halt_q, halt_d, known_q, known_d;
  logic hs, last;
  logic [3:0] cur_ic;
  function automatic logic [3:0] ilen(input logic [3:0] ic);
    return ic inside {4'h7, 4'h8} ? 4'd9 : ic inside {4'h3, 4'h4, 4'h5} ? 4'd10 :
           ic inside {4'h2, 4'h6, 4'hA, 4'hB} ? 4'd2 : 4'd1;
  endfunction
  function automatic logic legal(input logic [3:0] ic, input logic [3:0] fn);
    return ic == 4'h6 ? fn <= 4'd3 : (ic == 4'h2 || ic == 4'h7) ? fn <= 4'd6 : (ic <= 4'hB && fn == 4'd0);
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      k_q     <= '0;
      icode_q <= '0;
      ifun_q  <= '0;
      ra_q    <= 4'hF;
      rb_q    <= 4'hF;
      valc_q  <= '0;
      valp_q  <= '0;
      iv_q    <= 1'b0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
      known_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      k_q     <= k_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      iv_q    <= iv_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
      known_q <= known_d;
    end
  end
  // byte 0 decides the length on the same edge it arrives
  assign hs     = mem.mem_req & mem.mem_ack;
  assign cur_ic = k_q == 4'd0 ? mem.mem_rdata[7:4] : icode_q;
  assign last   = k_q == ilen(cur_ic) - 4'd1;
  always_comb begin
    state_d = state_q == IDLE  ? (start ? FETCH : IDLE) :
              state_q == FETCH ? (hs && (mem.mem_err || last) ? DONE : FETCH) : IDLE;
  end
  always_comb begin
    pc_d = pc_q;
    k_d = k_q;
    icode_d = icode_q;
    ifun_d = ifun_q;
    ra_d = ra_q;
    rb_d = rb_q;
    valc_d = valc_q;
    valp_d = valp_q;
    iv_d = iv_q;
    err_d = err_q;
    halt_d = halt_q;
    known_d = known_q;
    if (state_q == IDLE && start) begin
      pc_d = PC;
      k_d = '0;
      icode_d = '0;
      ifun_d = '0;
      ra_d = 4'hF;
      rb_d = 4'hF;
      valc_d = '0;
      err_d = 1'b0;
      known_d = 1'b0;
    end else if (state_q == FETCH && hs) begin
      k_d = k_q + 4'd1;
      if (mem.mem_err) err_d = 1'b1;
      else begin
        if (k_q == 4'd0) begin
          {icode_d, ifun_d} = mem.mem_rdata;
          known_d = 1'b1;
        end
        if (k_q == 4'd1 && ilen(icode_q) inside {4'd2, 4'd10}) {ra_d, rb_d} = mem.mem_rdata;
        if (icode_q inside {4'h7, 4'h8} && k_q != 4'd0) valc_d[{k_q[2:0] - 3'd1, 3'b000} +: 8] = mem.mem_rdata;
        if (icode_q inside {4'h3, 4'h4, 4'h5} && k_q >= 4'd2) valc_d[{k_q[2:0] - 3'd2, 3'b000} +: 8] = mem.mem_rdata;
      end
      if (state_d == DONE) begin
        valp_d = pc_q + ADDR_W'(known_d ? ilen(icode_d) : 4'd1);
        iv_d = known_d & ~err_d & legal(icode_d, ifun_d);
        halt_d = iv_d & (icode_d == 4'h0);
      end
    end
  end
  always_comb begin
    mem.mem_req  = state_q == FETCH;
    mem.mem_addr = pc_q + ADDR_W'(k_q);
    busy         = state_q == FETCH;
    done         = state_q == DONE;
    icode        = icode_q;
    ifun         = ifun_q;
    rA           = ra_q;
    rB           = rb_q;
    valC         = valc_q;
    valP         = valp_q;
    instr_valid  = iv_q;
    imem_error   = err_q;
    halt         = halt_q;
  end
endmodule
